// File: rtl/si5340_cfg_pkg.sv
// Shared definitions for the SI5340 configuration sequencer.
//   state_e      : sequencer FSM states
//   PAGE_REG     : SI5340 page-select register address
//   *_LSB        : bit positions of the page/register/data fields in a ROM word
package si5340_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PAGE_TX,
    S_REG_TX,
    S_NEXT,
    S_PAUSE,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [7:0] PAGE_REG = 8'h01;

  // ROM word layout: [23:16] page, [15:8] register, [7:0] data
  localparam int unsigned PAGE_LSB = 16;
  localparam int unsigned REG_LSB  = 8;
  localparam int unsigned DATA_LSB = 0;

endpackage

// File: rtl/si5340_cfg_sequencer_pause_timer.sv
// Down-counter for the post-preamble settling pause.
//   clk_i, arstn_i : clock, async active-low reset
//   load_i         : preset the counter to CYCLES
//   count_i        : decrement while high
//   expire_o       : high during the last counting cycle (count_i && cnt == 1), so a
//                    caller that counts from the cycle after load_i sees exactly
//                    CYCLES counting cycles including the expiring one
module cfg_pause_timer #(
  parameter int unsigned CYCLES = 50
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int unsigned CW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                       cnt_d = CW'(CYCLES);
    else if (count_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expire_o = count_i && (cnt_q == CW'(1));

endmodule

// File: rtl/si5340_cfg_sequencer.sv
// SI5340 power-up configuration sequencer.
// Walks the external config ROM once per start_i and turns each {page,reg,data} word
// into paged I2C writes through a byte-level I2C master.
//   clk_i, arstn_i         : clock, async active-low reset
//   start_i                : start a full ROM pass (ignored while busy_o)
//   mem_addr_o / mem_data_i: synchronous ROM port (data one cycle after address)
//   tx_valid_o/tx_ready_i  : byte handshake to the I2C master
//   tx_data_o, tx_start_o, tx_stop_o : byte and its START/STOP qualifiers
//   rx_done_i, rx_nack_i   : completion (and ACK status) of the accepted byte
//   busy_o, done_o, error_o: pass status; done/error hold until the next start
module si5340_cfg_sequencer
  import si5340_cfg_pkg::*;
#(
  parameter int unsigned MEM_WIDTH      = 24,
  parameter int unsigned WORD_NUMBER    = 326,
  parameter int unsigned PREAMBLE_WORDS = 3,
  parameter logic [6:0]  SLAVE_ADDR     = 7'h74,
  parameter int unsigned CLK_FREQ       = 125_000_000,
  parameter int unsigned PAUSE_MS       = 300,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                           clk_i,
  input  logic                           arstn_i,
  input  logic                           start_i,
  output logic [$clog2(WORD_NUMBER)-1:0] mem_addr_o,
  input  logic [MEM_WIDTH-1:0]           mem_data_i,
  output logic                           tx_valid_o,
  input  logic                           tx_ready_i,
  output logic [7:0]                     tx_data_o,
  output logic                           tx_start_o,
  output logic                           tx_stop_o,
  input  logic                           rx_done_i,
  input  logic                           rx_nack_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           error_o
);

  localparam int unsigned IW           = $clog2(WORD_NUMBER);
  localparam int unsigned RW           = $clog2(MAX_RETRY + 2);
  localparam int unsigned PAUSE_CYCLES = (CLK_FREQ / 1000) * PAUSE_MS;
  localparam bit          PAUSE_EN     = (PREAMBLE_WORDS != 0) && (PAUSE_CYCLES != 0);
  localparam int unsigned PRE_LAST     = (PREAMBLE_WORDS == 0) ? 0 : PREAMBLE_WORDS - 1;
  localparam logic [7:0]  ADDR_WR      = {SLAVE_ADDR, 1'b0};

  state_e                 state_q, state_d;
  logic [IW-1:0]          index_q, index_d;
  logic [MEM_WIDTH-1:0]   word_q, word_d;
  logic [1:0]             byte_q, byte_d;      // byte position within the 3-byte transaction
  logic                   inflight_q, inflight_d;  // byte accepted, waiting for rx_done_i
  logic [RW-1:0]          retry_q, retry_d;
  logic [RW-1:0]          retry_inc;
  logic [7:0]             page_q, page_d;
  logic                   page_vld_q, page_vld_d;
  logic                   tmr_load, tmr_count, tmr_expire;
  logic                   in_tx;

  wire [7:0] w_page = word_q[PAGE_LSB +: 8];
  wire [7:0] w_reg  = word_q[REG_LSB  +: 8];
  wire [7:0] w_data = word_q[DATA_LSB +: 8];

  cfg_pause_timer #(.CYCLES(PAUSE_CYCLES)) u_pause (
    .clk_i    (clk_i),
    .arstn_i  (arstn_i),
    .load_i   (tmr_load),
    .count_i  (tmr_count),
    .expire_o (tmr_expire)
  );

  assign in_tx      = (state_q == S_PAGE_TX) || (state_q == S_REG_TX);
  assign tx_valid_o = in_tx && !inflight_q;
  assign retry_inc  = retry_q + 1'b1;

  // Byte mux: both transactions are {addr_wr(start), X, Y(stop)}
  always_comb begin
    tx_data_o  = ADDR_WR;
    tx_start_o = 1'b0;
    tx_stop_o  = 1'b0;
    case (byte_q)
      2'd0:    tx_start_o = 1'b1;
      2'd1:    tx_data_o  = (state_q == S_PAGE_TX) ? PAGE_REG : w_reg;
      default: begin
        tx_data_o = (state_q == S_PAGE_TX) ? w_page : w_data;
        tx_stop_o = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    word_d     = word_q;
    byte_d     = byte_q;
    inflight_d = inflight_q;
    retry_d    = retry_q;
    page_d     = page_q;
    page_vld_d = page_vld_q;
    tmr_load   = 1'b0;
    tmr_count  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d    = S_FETCH;
          index_d    = '0;
          // A new pass cannot trust the device's page register.
          page_vld_d = 1'b0;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        word_d     = mem_data_i;
        retry_d    = '0;
        byte_d     = '0;
        inflight_d = 1'b0;
        state_d    = (page_vld_q && mem_data_i[PAGE_LSB +: 8] == page_q) ? S_REG_TX : S_PAGE_TX;
      end
      S_PAGE_TX, S_REG_TX: begin
        if (!inflight_q) begin
          // rx_done_i here (including same-cycle as accept) belongs to no byte.
          if (tx_ready_i) inflight_d = 1'b1;
        end else if (rx_done_i) begin
          inflight_d = 1'b0;
          if (rx_nack_i) begin
            page_vld_d = 1'b0;
            retry_d    = retry_inc;
            byte_d     = '0;
            state_d    = (retry_inc > RW'(MAX_RETRY)) ? S_ERROR : S_PAGE_TX;
          end else if (byte_q == 2'd2) begin
            byte_d = '0;
            if (state_q == S_PAGE_TX) begin
              page_d     = w_page;
              page_vld_d = 1'b1;
              state_d    = S_REG_TX;
            end else begin
              state_d = S_NEXT;
            end
          end else begin
            byte_d = byte_q + 2'd1;
          end
        end
      end
      S_NEXT: begin
        if (index_q == IW'(WORD_NUMBER - 1)) begin
          state_d = S_DONE;
        end else begin
          index_d = index_q + 1'b1;
          if (PAUSE_EN && index_q == IW'(PRE_LAST)) begin
            state_d  = S_PAUSE;
            tmr_load = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_PAUSE: begin
        tmr_count = 1'b1;
        if (tmr_expire) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      word_q     <= '0;
      byte_q     <= '0;
      inflight_q <= 1'b0;
      retry_q    <= '0;
      page_q     <= '0;
      page_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      word_q     <= word_d;
      byte_q     <= byte_d;
      inflight_q <= inflight_d;
      retry_q    <= retry_d;
      page_q     <= page_d;
      page_vld_q <= page_vld_d;
    end
  end

  assign mem_addr_o = index_q;
  assign busy_o     = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
  assign done_o     = (state_q == S_DONE);
  assign error_o    = (state_q == S_ERROR);

endmodule

// File: tb/tb_si5340_cfg_sequencer.sv
module tb_si5340_cfg_sequencer;

  localparam int NW   = 5;
  localparam int PRE  = 2;
  localparam int PC   = 50;
  localparam int MAXR = 3;

  logic        clk = 0;
  logic        arstn_i = 0;
  logic        start_i = 0;
  logic [2:0]  mem_addr_o;
  logic [23:0] mem_data_i;
  logic        tx_valid_o;
  logic        tx_ready_i = 0;
  logic [7:0]  tx_data_o;
  logic        tx_start_o, tx_stop_o;
  logic        rx_done_i = 0;
  logic        rx_nack_i = 0;
  logic        busy_o, done_o, error_o;

  si5340_cfg_sequencer #(
    .MEM_WIDTH(24), .WORD_NUMBER(NW), .PREAMBLE_WORDS(PRE), .SLAVE_ADDR(7'h74),
    .CLK_FREQ(50_000), .PAUSE_MS(1), .MAX_RETRY(MAXR)
  ) dut (
    .clk_i(clk), .arstn_i(arstn_i), .start_i(start_i),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o),
    .tx_start_o(tx_start_o), .tx_stop_o(tx_stop_o),
    .rx_done_i(rx_done_i), .rx_nack_i(rx_nack_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  logic [23:0] rom [NW];
  always @(posedge clk) mem_data_i <= rom[mem_addr_o];

  typedef struct {
    logic [7:0] data;
    bit         st;
    bit         sp;
    int         gap;   // cycles from this byte's rx_done to the next tx_valid_o; -1 = none
  } exp_t;

  exp_t exp_q[$];
  int   nack_q[$];
  bit   exp_err;
  int   n_chk = 0, n_fail = 0;
  int   byte_idx = 0, acc_cnt = 0, stall = 0;
  bit   spur_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_nack(input int i);
    foreach (nack_q[k]) if (nack_q[k] == i) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: expected byte stream of one pass from the ROM contents and NACK plan.
  task automatic build_model();
    int bi, retry;
    bit cv, do_page, nacked;
    logic [7:0] cp, pg, rg, dt;
    logic [7:0] seq[$];
    exp_t e;
    exp_q.delete();
    exp_err = 0; bi = 0; cv = 0; cp = 0;
    for (int w = 0; w < NW; w++) begin
      pg = rom[w][23:16]; rg = rom[w][15:8]; dt = rom[w][7:0];
      retry = 0;
      do_page = !cv || (cp != pg);
      forever begin
        seq.delete();
        if (do_page) begin
          seq.push_back(8'hE8); seq.push_back(8'h01); seq.push_back(pg);
        end
        seq.push_back(8'hE8); seq.push_back(rg); seq.push_back(dt);
        nacked = 0;
        for (int k = 0; k < seq.size(); k++) begin
          e.data = seq[k]; e.st = (k % 3 == 0); e.sp = (k % 3 == 2);
          if (is_nack(bi)) begin
            retry++; nacked = 1;
            e.gap = (retry > MAXR) ? -1 : 1;
          end else if (k % 3 != 2 || k < seq.size() - 1) e.gap = 1;
          else if (w == NW - 1)  e.gap = -1;
          else if (w == PRE - 1) e.gap = 4 + PC;
          else                   e.gap = 4;
          exp_q.push_back(e);
          bi++;
          if (nacked) break;
        end
        if (!nacked) begin cv = 1; cp = pg; break; end
        cv = 0; do_page = 1;
        if (retry > MAXR) begin exp_err = 1; return; end
      end
    end
  endtask

  // I2C slave model + scoreboard monitor, all on the falling edge.
  int   lat_cnt = 0, pend_gap = -1, gap_cnt = 0, gap_exp = 0;
  bit   pend_nack = 0, track = 0, prev_offer = 0;
  logic [9:0] prev_bits = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!arstn_i) begin
        lat_cnt = 0; track = 0; prev_offer = 0;
        tx_ready_i = 0; rx_done_i = 0; rx_nack_i = 0;
      end else begin
        if (track) begin
          gap_cnt++;
          if (tx_valid_o) begin
            chk("next_byte_gap", 32'(gap_cnt), 32'(gap_exp)); track = 0;
          end else if (gap_cnt > gap_exp + 8) begin
            chk("next_byte_timeout", 32'(gap_cnt), 32'(gap_exp)); track = 0;
          end
        end
        if (prev_offer) begin
          chk("hold_valid", 32'(tx_valid_o), 32'd1);
          chk("hold_bits", 32'({tx_start_o, tx_stop_o, tx_data_o}), 32'(prev_bits));
        end
        rx_done_i = 0; rx_nack_i = 0;
        if (lat_cnt > 0) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            rx_done_i = 1; rx_nack_i = pend_nack;
            if (pend_gap >= 0) begin track = 1; gap_cnt = 0; gap_exp = pend_gap; end
          end
        end else if (spur_en && $urandom_range(0, 11) == 0) begin
          rx_done_i = 1; rx_nack_i = 1'($urandom_range(0, 1));
        end
        if (stall > 0) begin stall--; tx_ready_i = 0; end
        else tx_ready_i = ($urandom_range(0, 2) != 0);
        if (tx_valid_o && tx_ready_i && lat_cnt == 0) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_byte: got %0h, expected no byte", tx_data_o);
            pend_gap = -1;
          end else begin
            e = exp_q.pop_front();
            chk("byte", 32'({tx_start_o, tx_stop_o, tx_data_o}), 32'({e.st, e.sp, e.data}));
            pend_gap = e.gap;
          end
          pend_nack = is_nack(byte_idx);
          byte_idx++;
          lat_cnt = $urandom_range(1, 4);
        end
        prev_offer = tx_valid_o && !tx_ready_i;
        prev_bits  = {tx_start_o, tx_stop_o, tx_data_o};
      end
    end
  end

  task automatic run_pass(input bit poke, input bit want_rst);
    bit poked = 0;
    build_model();
    byte_idx = 0; acc_cnt = 0;
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    chk("busy_after_start", 32'(busy_o), 32'd1);
    chk("done_cleared", 32'(done_o), 32'd0);
    chk("error_cleared", 32'(error_o), 32'd0);
    for (int c = 0; c < 4000 && busy_o; c++) begin
      @(negedge clk);
      start_i = 0;
      if (poke && !poked && acc_cnt >= 8 && tx_valid_o) begin
        stall = 20; start_i = 1; poked = 1;   // start_i while busy must be ignored
      end
      if (want_rst && acc_cnt >= 4 && acc_cnt <= 5 && tx_valid_o) begin
        stall = 5;
        #2 chk("valid_before_reset", 32'(tx_valid_o), 32'd1);
        arstn_i = 0;
        #1 chk("valid_dropped_by_reset", 32'(tx_valid_o), 32'd0);
        chk("busy_dropped_by_reset", 32'(busy_o), 32'd0);
        chk("addr_after_reset", 32'(mem_addr_o), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        arstn_i = 1;
        @(negedge clk);
        return;
      end
    end
    start_i = 0;
    chk("pass_terminated", 32'(busy_o), 32'd0);
    chk("done_o", 32'(done_o), 32'(!exp_err));
    chk("error_o", 32'(error_o), 32'(exp_err));
    chk("bytes_left", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_rom();
    logic [7:0] pages [3];
    pages[0] = 8'h0B; pages[1] = 8'h00; pages[2] = 8'h05;
    for (int i = 0; i < NW; i++)
      rom[i] = {pages[$urandom_range(0, 2)], 8'($urandom), 8'($urandom)};
  endtask

  task automatic ref_rom();
    rom[0] = 24'h0B24C0; rom[1] = 24'h0B25FF; rom[2] = 24'h002211;
    rom[3] = 24'h003344; rom[4] = 24'h00AA55;
  endtask

  initial begin
    ref_rom();
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    chk("rst_addr", 32'(mem_addr_o), 32'd0);
    arstn_i = 1;
    repeat (2) @(negedge clk);
    spur_en = 1;

    // reference ROM, one NACK on word 3 data byte, ready stall + start while busy
    nack_q.delete(); nack_q.push_back(17);
    run_pass(1'b1, 1'b0);
    // four NACKs in a row on word 0 -> error
    nack_q.delete();
    for (int i = 2; i < 6; i++) nack_q.push_back(i);
    run_pass(1'b0, 1'b0);
    // random ROM contents and NACK plans
    for (int p = 0; p < 5; p++) begin
      rand_rom();
      nack_q.delete();
      for (int k = $urandom_range(0, 4); k > 0; k--) nack_q.push_back($urandom_range(0, 30));
      run_pass(1'b0, 1'b0);
    end
    // reset mid-REG_TX, then a clean pass from word 0 with the page rewritten
    ref_rom();
    nack_q.delete();
    run_pass(1'b0, 1'b1);
    chk("idle_after_reset_done", 32'(done_o), 32'd0);
    run_pass(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
